// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage
//
// Owns the PC, issues one word fetch at a time to instruction memory and
// presents a registered instruction/PC pair to decode. Redirects (jump_i)
// win over everything, including stall_i. A request that is already in
// flight when a redirect arrives has its response dropped through the
// discard flag.
//
// Optional feature: define IF_MISALIGN_TRAP_EN to trap misaligned redirect
// targets. When it is defined, fetch_misalign_o goes high and stays high,
// and fetching stops until an aligned redirect arrives. When it is not
// defined, the low two target bits are forced to zero and fetch_misalign_o
// stays 0.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   imem_req_o        fetch request valid (combinational from state)
//   imem_addr_o       fetch address (current PC)
//   imem_gnt_i        memory accepts the request this cycle
//   imem_rvalid_i     read data valid, one per granted request
//   imem_rdata_i      instruction word
//   stall_i           decode cannot take a new instruction; hold outputs
//   jump_i            redirect request
//   jump_addr_i       redirect target
//   inst_o            instruction to decode (NOP_INST while invalid)
//   inst_addr_o       PC of inst_o
//   inst_valid_o      inst_o / inst_addr_o valid
//   fetch_misalign_o  sticky misaligned-redirect flag
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | request pc to imem (suppressed while the misalign flag is set)
// WAIT  | one request outstanding; waiting for rvalid
// HOLD  | word received while decode stalled; parked in the hold buffer
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        fetch_misalign_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] inst_d, addr_d;
    logic        valid_d;
    logic        discard_q, discard_d;
    logic        misalign_q, misalign_d;
    logic [31:0] jump_target;
    logic        jump_misalign;

`ifdef IF_MISALIGN_TRAP_EN
    // Raw target is kept in pc so the faulting address stays visible.
    assign jump_misalign = (jump_addr_i[1:0] != 2'b00);
    assign jump_target   = jump_addr_i;
`else
    assign jump_misalign = 1'b0;
    assign jump_target   = {jump_addr_i[31:2], 2'b00};
`endif

    assign imem_req_o       = (state_q == S_REQ) && !misalign_q;
    assign imem_addr_o      = pc_q;
    assign fetch_misalign_o = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_q       <= 32'd0;
            inst_o       <= NOP_INST;
            inst_addr_o  <= 32'd0;
            inst_valid_o <= 1'b0;
            discard_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            inst_o       <= inst_d;
            inst_addr_o  <= addr_d;
            inst_valid_o <= valid_d;
            discard_q    <= discard_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        inst_d     = inst_o;
        addr_d     = inst_addr_o;
        valid_d    = inst_valid_o;
        discard_d  = discard_q;
        misalign_d = misalign_q;

        // A valid output is consumed whenever decode is not stalled; a load
        // below overrides this in the same cycle.
        if (inst_valid_o && !stall_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        if (jump_i) begin
            pc_d       = jump_target;
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            misalign_d = jump_misalign;
            discard_d  = 1'b0;
            state_d    = S_REQ;
            // A response still to come belongs to the old stream: wait it out.
            if ((state_q == S_WAIT && !imem_rvalid_i) || (imem_req_o && imem_gnt_i)) begin
                discard_d = 1'b1;
                state_d   = S_WAIT;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_o && imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (!inst_valid_o || !stall_i) begin
                            inst_d  = imem_rdata_i;
                            addr_d  = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + 32'd4;
                            state_d = S_REQ;
                        end else begin
                            hold_d  = imem_rdata_i;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        inst_d  = hold_q;
                        addr_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch
//
// The memory responder and the reference model work at the level of the
// instruction stream. The expected stream runs sequentially from the reset
// PC and restarts at each redirect target. Every delivered word must equal
// mem_word(its address). Responses to requests that a redirect overtook are
// expected to vanish. A directed prologue covers reset, streaming, stall,
// in-flight redirect and misaligned redirect. A long randomized run follows.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_misalign_o;

    if_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .stall_i          (stall_i),
        .jump_i           (jump_i),
        .jump_addr_i      (jump_addr_i),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .inst_valid_o     (inst_valid_o),
        .fetch_misalign_o (fetch_misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // memory responder state
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned cnt     = 0;
    logic        outstanding = 1'b0;
    logic [31:0] out_addr    = 32'd0;

    // reference stream state
    logic [31:0] exp_pc  = 32'd0;
    logic        exp_mis = 1'b0;
    logic        stale   = 1'b0;
    logic        held    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hF065_0513;
            32'h0000_0004: return 32'h0005_2F03;
            32'h0000_0008: return 32'hDEAD_BEEF;
            default:       return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic drive_mem();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        if (outstanding) begin
            if (cnt <= 1) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(out_addr);
            end else begin
                cnt--;
            end
        end
        imem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        jump_i        = 1'b0;
        jump_addr_i   = 32'd0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        #1;
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, NOP);
        check("rst_inst_addr", inst_addr_o, 32'd0);
        check("rst_misalign", 32'(fetch_misalign_o), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        outstanding = 1'b0;
        cnt         = 0;
        stale       = 1'b0;
        held        = 1'b0;
        exp_pc      = 32'd0;
        exp_mis     = 1'b0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd1);
        check("rst_req_addr", imem_addr_o, 32'd0);
        drive_mem();
    endtask

    // One clock: snapshot what the DUT sees at the edge, advance, then judge
    // the new outputs against the stream model.
    task automatic cycle();
        logic        p_req, p_gnt, p_rv, p_stall, p_jump, p_valid;
        logic [31:0] p_addr, p_jaddr, p_inst, p_iaddr;
        logic        load, hold_out;
        p_req   = imem_req_o;
        p_addr  = imem_addr_o;
        p_gnt   = imem_gnt_i;
        p_rv    = imem_rvalid_i;
        p_stall = stall_i;
        p_jump  = jump_i;
        p_jaddr = jump_addr_i;
        p_valid = inst_valid_o;
        p_inst  = inst_o;
        p_iaddr = inst_addr_o;
        @(posedge clk);
        @(negedge clk);

        if (p_rv) outstanding = 1'b0;
        if (p_req && p_gnt) begin
            outstanding = 1'b1;
            out_addr    = p_addr;
            cnt         = $urandom_range(lat_max, lat_min);
        end
        if (outstanding) check("no_req_while_pending", 32'(imem_req_o), 32'd0);

        load = 1'b0;
        if (p_jump) begin
            stale = outstanding;
            held  = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            exp_pc  = p_jaddr;
            exp_mis = (p_jaddr[1:0] != 2'b00);
`else
            exp_pc  = p_jaddr & ~32'h3;
`endif
        end else if (p_rv) begin
            if (stale) stale = 1'b0;
            else if (!p_valid || !p_stall) load = 1'b1;
            else held = 1'b1;
        end else if (held && !p_stall) begin
            held = 1'b0;
            load = 1'b1;
        end

        hold_out = p_valid && p_stall && !p_jump;
        check("inst_valid", 32'(inst_valid_o), 32'(load || hold_out));
        if (hold_out) begin
            check("hold_inst", inst_o, p_inst);
            check("hold_addr", inst_addr_o, p_iaddr);
        end else if (load) begin
            check("inst_addr", inst_addr_o, exp_pc);
            check("inst_data", inst_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end else begin
            check("nop_inst", inst_o, NOP);
        end

        if (p_req && !p_gnt && !p_jump) begin
            check("req_stable", 32'(imem_req_o), 32'd1);
            check("req_addr_stable", imem_addr_o, p_addr);
        end
        if (imem_req_o) check("req_align", 32'(imem_addr_o[1:0]), 32'd0);
        check("misalign_flag", 32'(fetch_misalign_o), 32'(exp_mis));

        drive_mem();
    endtask

    initial begin
        logic [31:0] tgt;
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        jump_i        = 1'b0;
        jump_addr_i   = 32'd0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        @(negedge clk);

        // stream with zero-wait memory
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        cycle(); cycle();
        check("t2_inst0", inst_o, 32'hF065_0513);
        check("t2_addr0", inst_addr_o, 32'h0);
        cycle();
        check("t2_gap_valid", 32'(inst_valid_o), 32'd0);
        cycle();
        check("t2_inst1", inst_o, 32'h0005_2F03);
        check("t2_addr1", inst_addr_o, 32'h4);

        // reset while a fetch is outstanding
        cycle();
        check("t1_in_wait", 32'(imem_req_o), 32'd0);
        do_reset();

        // stall while the 0x4 response arrives
        cycle(); cycle();
        stall_i = 1'b1;
        repeat (5) cycle();
        check("t3_stalled_inst", inst_o, 32'hF065_0513);
        check("t3_stalled_valid", 32'(inst_valid_o), 32'd1);
        stall_i = 1'b0;
        cycle();
        check("t3_release_inst", inst_o, 32'h0005_2F03);
        check("t3_release_addr", inst_addr_o, 32'h4);
        check("t3_next_req", 32'(imem_req_o), 32'd1);
        check("t3_next_addr", imem_addr_o, 32'h8);

        // redirect while the 0x8 fetch is in flight, response 3 cycles later
        lat_min = 3; lat_max = 3;
        cycle();
        jump_i = 1'b1; jump_addr_i = 32'h100;
        cycle();
        jump_i = 1'b0;
        cycle(); cycle();
        check("t4_req", 32'(imem_req_o), 32'd1);
        check("t4_req_addr", imem_addr_o, 32'h100);
        check("t4_valid", 32'(inst_valid_o), 32'd0);

        // jump with rvalid, then jump with gnt
        lat_min = 1; lat_max = 1;
        cycle();
        jump_i = 1'b1; jump_addr_i = 32'h200;
        cycle();
        check("t5a_req_addr", imem_addr_o, 32'h200);
        check("t5a_req", 32'(imem_req_o), 32'd1);
        jump_addr_i = 32'h300;
        cycle();
        jump_i = 1'b0;
        check("t5b_discard_wait", 32'(imem_req_o), 32'd0);
        cycle(); cycle(); cycle();
        check("t5_target_valid", 32'(inst_valid_o), 32'd1);
        check("t5_target_addr", inst_addr_o, 32'h300);

        // misaligned redirect
        jump_i = 1'b1; jump_addr_i = 32'h102;
        cycle();
        jump_i = 1'b0;
        cycle();
`ifdef IF_MISALIGN_TRAP_EN
        check("t6_flag_set", 32'(fetch_misalign_o), 32'd1);
        check("t6_parked", 32'(imem_req_o), 32'd0);
        jump_i = 1'b1; jump_addr_i = 32'h200;
        cycle();
        jump_i = 1'b0;
        check("t6_flag_clear", 32'(fetch_misalign_o), 32'd0);
        check("t6_resume_req", 32'(imem_req_o), 32'd1);
        check("t6_resume_addr", imem_addr_o, 32'h200);
`else
        check("t6_forced_addr", imem_addr_o, 32'h100);
        check("t6_req", 32'(imem_req_o), 32'd1);
        check("t6_flag", 32'(fetch_misalign_o), 32'd0);
`endif

        // randomized traffic
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom_range(99, 0) < 30);
            jump_i  = ($urandom_range(99, 0) < 6);
            tgt     = $urandom();
            case ($urandom_range(3, 0))
                0:       tgt = 32'hFFFF_FFF0 | (tgt & 32'hB);
                1:       tgt = tgt & 32'h0000_0FFF;
                default: tgt = tgt;
            endcase
`ifdef IF_MISALIGN_TRAP_EN
            tgt = tgt & ~32'h3;
`endif
            jump_addr_i = tgt;
            cycle();
        end
        stall_i = 1'b0;
        jump_i  = 1'b0;
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
